// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 sequencer: opcodes, adder operand select
// encodings, load strobe bit indices and the sequencer state encoding.
package td4_pkg;
  localparam logic [3:0] OP_ADD_A  = 4'h0;
  localparam logic [3:0] OP_MOV_AB = 4'h1;
  localparam logic [3:0] OP_IN_A   = 4'h2;
  localparam logic [3:0] OP_MOV_AI = 4'h3;
  localparam logic [3:0] OP_MOV_BA = 4'h4;
  localparam logic [3:0] OP_ADD_B  = 4'h5;
  localparam logic [3:0] OP_IN_B   = 4'h6;
  localparam logic [3:0] OP_MOV_BI = 4'h7;
  localparam logic [3:0] OP_OUT_B  = 4'h9;
  localparam logic [3:0] OP_OUT_I  = 4'hB;
  localparam logic [3:0] OP_JNC    = 4'hE;
  localparam logic [3:0] OP_JMP    = 4'hF;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;
endpackage

// File: rtl/td4_sequencer_if.sv
// Bundle between the TD4 sequencer and its surroundings (control inputs,
// ROM byte, adder carry in; load strobes, operand select, immediate, PC
// increment, carry flag and status out).
//   master : the sequencer side
//   slave  : the ROM / datapath / control side
interface td4_sequencer_if;
  logic       run;
  logic       step;
  logic [7:0] rom_data;
  logic       alu_carry;
  logic [3:0] load;
  logic [1:0] sel;
  logic [3:0] imm;
  logic       pc_inc;
  logic       carry_flag;
  logic       busy;
  logic       illegal;

  modport master (
    input  run, step, rom_data, alu_carry,
    output load, sel, imm, pc_inc, carry_flag, busy, illegal
  );
  modport slave (
    output run, step, rom_data, alu_carry,
    input  load, sel, imm, pc_inc, carry_flag, busy, illegal
  );
endinterface

// File: rtl/td4_decode.sv
// Combinational TD4 instruction decoder.
//   opcode     : IR[7:4]
//   carry_flag : registered carry, consulted by JNC
//   load       : one-hot strobes {PC, OUT, B, A}
//   sel        : adder operand source
//   pc_inc     : increment PC (never together with load[LD_PC])
//   is_add     : instruction updates carry from the adder
//   illegal    : opcode is undefined
// Outputs are raw; the sequencer qualifies them with its EXEC state.
module td4_decode
  import td4_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  output logic [3:0] load,
  output logic [1:0] sel,
  output logic       pc_inc,
  output logic       is_add,
  output logic       illegal
);
  always_comb begin
    load    = '0;
    sel     = SEL_A;
    pc_inc  = 1'b1;
    is_add  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_ADD_A:  begin sel = SEL_A;    load[LD_A]   = 1'b1; is_add = 1'b1; end
      OP_MOV_AB: begin sel = SEL_B;    load[LD_A]   = 1'b1; end
      OP_IN_A:   begin sel = SEL_IN;   load[LD_A]   = 1'b1; end
      OP_MOV_AI: begin sel = SEL_ZERO; load[LD_A]   = 1'b1; end
      OP_MOV_BA: begin sel = SEL_A;    load[LD_B]   = 1'b1; end
      OP_ADD_B:  begin sel = SEL_B;    load[LD_B]   = 1'b1; is_add = 1'b1; end
      OP_IN_B:   begin sel = SEL_IN;   load[LD_B]   = 1'b1; end
      OP_MOV_BI: begin sel = SEL_ZERO; load[LD_B]   = 1'b1; end
      OP_OUT_B:  begin sel = SEL_B;    load[LD_OUT] = 1'b1; end
      OP_OUT_I:  begin sel = SEL_ZERO; load[LD_OUT] = 1'b1; end
      // Jump target is the immediate routed through the adder with a zero operand.
      OP_JMP:    begin sel = SEL_ZERO; load[LD_PC]  = 1'b1; pc_inc = 1'b0; end
      OP_JNC: begin
        sel = SEL_ZERO;
        if (!carry_flag) begin
          load[LD_PC] = 1'b1;
          pc_inc      = 1'b0;
        end
      end
      default:   illegal = 1'b1;  // NOP, PC still advances
    endcase
  end
endmodule

// File: rtl/td4_sequencer.sv
// TD4 fetch/execute sequencer. Fetches IR from ROM over ROM_LATENCY cycles,
// then spends one EXEC cycle driving the decoded strobes; carry flag is
// updated at the end of EXEC. Free-run (run=1) or single-step (step edge).
//   clock, reset : clock, async active-low reset
//   bus (master) : run/step/rom_data/alu_carry in;
//                  load/sel/imm/pc_inc/carry_flag/busy/illegal out
// Parameter ROM_LATENCY (1..7): FETCH length in cycles.
// Macro TD4_ILLEGAL_TRAP_EN: undefined opcodes halt the sequencer (no PC
// increment) until reset instead of executing as NOPs.
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int ROM_LATENCY = 1
) (
  input  logic          clock,
  input  logic          reset,
  td4_sequencer_if.master bus
);
  localparam logic [2:0] LAT_LAST = 3'(ROM_LATENCY - 1);

  state_t     state, state_nx;
  logic [2:0] lat_cnt, lat_cnt_nx;
  logic [7:0] ir;
  logic       step_q;
  logic       carry_q;
  logic       step_rise;
  logic       fetch_done;
  logic       exec;

  logic [3:0] dec_load;
  logic [1:0] dec_sel;
  logic       dec_pc_inc;
  logic       dec_is_add;
  logic       dec_illegal;

  td4_decode u_dec (
    .opcode     (ir[7:4]),
    .carry_flag (carry_q),
    .load       (dec_load),
    .sel        (dec_sel),
    .pc_inc     (dec_pc_inc),
    .is_add     (dec_is_add),
    .illegal    (dec_illegal)
  );

  // step_q tracks step in every state, so an edge seen while busy is dropped.
  assign step_rise  = bus.step & ~step_q;
  assign fetch_done = (state == ST_FETCH) && (lat_cnt == LAT_LAST);
  assign exec       = (state == ST_EXEC);

  always_comb begin
    state_nx   = state;
    lat_cnt_nx = lat_cnt;
    case (state)
      ST_IDLE:  if (bus.run || step_rise) state_nx = ST_FETCH;
      ST_FETCH: begin
        if (fetch_done) begin
          lat_cnt_nx = '0;
          state_nx   = ST_EXEC;
        end else begin
          lat_cnt_nx = lat_cnt + 3'd1;
        end
      end
      ST_EXEC: begin
`ifdef TD4_ILLEGAL_TRAP_EN
        if (dec_illegal)  state_nx = ST_HALT;
        else if (bus.run) state_nx = ST_FETCH;
        else              state_nx = ST_IDLE;
`else
        state_nx = bus.run ? ST_FETCH : ST_IDLE;
`endif
      end
      ST_HALT:  state_nx = ST_HALT;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
      ir      <= '0;
      step_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_cnt_nx;
      step_q  <= bus.step;
      if (fetch_done) ir <= bus.rom_data;
      // Only ADDs produce a carry; everything else (JNC included) clears it.
      if (exec) carry_q <= dec_is_add & bus.alu_carry;
    end
  end

  assign bus.load       = exec ? dec_load : 4'b0000;
  assign bus.sel        = exec ? dec_sel  : SEL_A;
  assign bus.imm        = ir[3:0];
  assign bus.carry_flag = carry_q;
  assign bus.busy       = (state == ST_FETCH) || exec;
  assign bus.illegal    = exec & dec_illegal;
`ifdef TD4_ILLEGAL_TRAP_EN
  assign bus.pc_inc     = exec & dec_pc_inc & ~dec_illegal;
`else
  assign bus.pc_inc     = exec & dec_pc_inc;
`endif
endmodule

// File: tb/tb_td4_sequencer.sv
// Directed bench for td4_sequencer: one instance with ROM_LATENCY=1 for the
// instruction/step/illegal checks, one with ROM_LATENCY=3 for throughput and
// run-deassert behaviour.
module tb_td4_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errs  = 0;
  int   total = 0;

  always #5 clock = ~clock;

  td4_sequencer_if ifc0 ();
  td4_sequencer_if ifc1 ();

  td4_sequencer #(.ROM_LATENCY(1)) u0 (.clock(clock), .reset(reset), .bus(ifc0));
  td4_sequencer #(.ROM_LATENCY(3)) u1 (.clock(clock), .reset(reset), .bus(ifc1));

  // Any strobe at all means the instance is in EXEC.
  wire ex0 = (|ifc0.load) | ifc0.pc_inc | ifc0.illegal;
  wire ex1 = (|ifc1.load) | ifc1.pc_inc | ifc1.illegal;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int       n;
    logic [3:0] ld;
    logic [1:0] sl;
    ifc0.run = 0; ifc0.step = 0; ifc0.rom_data = 0; ifc0.alu_carry = 0;
    ifc1.run = 0; ifc1.step = 0; ifc1.rom_data = 0; ifc1.alu_carry = 0;
    ld = 0; sl = 0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_load",  ifc0.load, 0);
    chk("rst_sel",   ifc0.sel, 0);
    chk("rst_imm",   ifc0.imm, 0);
    chk("rst_pcinc", ifc0.pc_inc, 0);
    chk("rst_carry", ifc0.carry_flag, 0);
    chk("rst_busy",  ifc0.busy, 0);
    chk("rst_ill",   ifc0.illegal, 0);

    // MOV A,5 with run=1: FETCH on cycle 1, EXEC on cycle 2
    ifc0.rom_data = 8'h35;
    ifc0.run = 1;
    @(posedge clock); #1 reset = 1;
    nxt();
    chk("f1_busy", ifc0.busy, 1);
    chk("f1_noex", ex0, 0);
    nxt();
    chk("mov_load",  ifc0.load, 4'b0001);
    chk("mov_sel",   ifc0.sel, 2'b11);
    chk("mov_imm",   ifc0.imm, 4'h5);
    chk("mov_pcinc", ifc0.pc_inc, 1);

    // ADD A,3 with carry out, then JNC 3 (not taken)
    ifc0.rom_data = 8'h03; ifc0.alu_carry = 1;
    nxt(); nxt();
    chk("add_load",   ifc0.load, 4'b0001);
    chk("add_sel",    ifc0.sel, 2'b00);
    chk("add_cf_pre", ifc0.carry_flag, 0);
    ifc0.rom_data = 8'hE3;
    nxt();
    chk("add_cf", ifc0.carry_flag, 1);
    nxt();
    chk("jnc1_load",  ifc0.load, 4'b0000);
    chk("jnc1_pcinc", ifc0.pc_inc, 1);
    chk("jnc1_imm",   ifc0.imm, 4'h3);
    ifc0.rom_data = 8'hE7; ifc0.alu_carry = 0;
    nxt();
    chk("jnc1_cf", ifc0.carry_flag, 0);
    nxt();
    chk("jnc0_load",  ifc0.load, 4'b1000);
    chk("jnc0_imm",   ifc0.imm, 4'h7);
    chk("jnc0_pcinc", ifc0.pc_inc, 0);
    ifc0.run = 0;
    nxt();
    chk("idle_busy", ifc0.busy, 0);

    // Single step: step held high gives one instruction
    ifc0.rom_data = 8'h7A;
    ifc0.step = 1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      nxt();
      if (ex0) begin n++; ld = ifc0.load; sl = ifc0.sel; end
    end
    chk("step1_cnt",  8'(n), 1);
    chk("step1_load", ld, 4'b0010);
    chk("step1_sel",  sl, 2'b11);
    chk("step1_busy", ifc0.busy, 0);
    ifc0.step = 0;
    nxt(); nxt();
    ifc0.step = 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      nxt();
      if (ex0) n++;
    end
    chk("step2_cnt", 8'(n), 1);
    ifc0.step = 0;

    // ROM_LATENCY=3: EXEC every 4th cycle, then run drop mid-FETCH
    ifc1.rom_data = 8'h90;
    ifc1.run = 1;
    for (int k = 0; k < 20 && !ex1; k++) nxt();
    chk("l3_first", ex1, 1);
    for (int i = 1; i <= 12; i++) begin
      nxt();
      chk($sformatf("l3_cyc%0d", i), ex1, (i % 4 == 0) ? 8'd1 : 8'd0);
    end
    nxt();
    chk("l3_f1_busy", ifc1.busy, 1);
    ifc1.run = 0;
    nxt(); nxt(); nxt();
    chk("l3_fin_ex",   ex1, 1);
    chk("l3_fin_load", ifc1.load, 4'b0100);
    chk("l3_fin_sel",  ifc1.sel, 2'b01);
    nxt();
    chk("l3_idle", ifc1.busy, 0);
    repeat (4) nxt();
    chk("l3_stay", ifc1.busy, 0);

    // Undefined opcode
    ifc0.rom_data = 8'h80;
    ifc0.run = 1;
    for (int k = 0; k < 10 && !ex0; k++) nxt();
    chk("ill_seen", ifc0.illegal, 1);
    chk("ill_load", ifc0.load, 0);
`ifdef TD4_ILLEGAL_TRAP_EN
    chk("ill_pcinc", ifc0.pc_inc, 0);
    nxt();
    chk("halt_busy", ifc0.busy, 0);
    chk("halt_ill",  ifc0.illegal, 0);
    ifc0.step = 1;
    repeat (5) nxt();
    chk("halt_stay", ifc0.busy, 0);
    chk("halt_nost", ex0, 0);
    ifc0.step = 0;
    reset = 0;
    nxt();
    reset = 1;
    ifc0.rom_data = 8'h35;
    nxt();
    chk("halt_rst_busy", ifc0.busy, 1);
`else
    chk("ill_pcinc", ifc0.pc_inc, 1);
    nxt();
    chk("ill_pulse", ifc0.illegal, 0);
    chk("ill_cont",  ifc0.busy, 1);
    for (int k = 0; k < 10 && !ex0; k++) nxt();
    chk("ill_again", ifc0.illegal, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1);
  end
endmodule

// File: doc/td4_sequencer.md
Name: td4_sequencer

Overview:
- Fetch/execute controller for the 4-bit TD4 CPU datapath.
- Reads the 8-bit instruction at the current PC from ROM and decodes it.
- Drives the one-hot load strobes for register A, register B, the output register and the program counter. Drives the adder operand select and keeps the carry flag.
- Supports free-run and single-step operation. Sits between the program ROM, the register file and the program_counter.

Parameters:
- ROM_LATENCY, 1, cycles from entering FETCH to rom_data being valid (1..7).

Ports:
- clock  in  1  system clock (internal CPU clock, already divided).
- reset  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- run  in  1  level; 1 = execute instructions back-to-back.
- step  in  1  rising edge executes exactly one instruction while run=0.
- rom_data  in  8  instruction byte: [7:4] opcode, [3:0] immediate.
- alu_carry  in  1  carry-out of the 4-bit adder during EXEC.
- load  out  4  one-hot strobes: [0] A, [1] B, [2] OUT, [3] PC parallel load.
- sel  out  2  adder operand source: 00 A, 01 B, 10 user_in, 11 zero.
- imm  out  4  latched immediate (IR[3:0]).
- pc_inc  out  1  PC increment strobe.
- carry_flag  out  1  registered carry flag.
- busy  out  1  1 while in FETCH or EXEC.
- illegal  out  1  one-cycle pulse in EXEC for an undefined opcode.

Behaviour:
- Reset (reset=0, async): state IDLE; load=0, sel=00, imm=0, pc_inc=0, carry_flag=0, busy=0, illegal=0; IR=0; latency counter=0; step edge detector cleared.
- States: IDLE, FETCH, EXEC (and HALT only with the optional feature).
- IDLE → FETCH when run=1, or on a step rising edge (step registered once; holding step high gives one instruction).
- FETCH: counts ROM_LATENCY cycles. On the last cycle, IR <= rom_data. Then → EXEC.
- EXEC lasts exactly 1 cycle; strobes are asserted only in EXEC. Opcodes:
  - 0000 ADD A,Im: sel=00, load[0].
  - 0001 MOV A,B: sel=01, load[0].
  - 0010 IN A: sel=10, load[0].
  - 0011 MOV A,Im: sel=11, load[0].
  - 0100 MOV B,A: sel=00, load[1].
  - 0101 ADD B,Im: sel=01, load[1].
  - 0110 IN B: sel=10, load[1].
  - 0111 MOV B,Im: sel=11, load[1].
  - 1001 OUT B: sel=01, load[2].
  - 1011 OUT Im: sel=11, load[2].
  - 1111 JMP Im: load[3].
  - 1110 JNC Im: load[3] if carry_flag=0, else pc_inc.
  - Undefined (1000, 1010, 1100, 1101): NOP with pc_inc=1 and illegal=1.
- pc_inc=1 in EXEC for every instruction that does not assert load[3]. load[3] and pc_inc are never both 1.
- Carry flag, updated at the end of EXEC:
  - ADD A,Im / ADD B,Im: carry_flag <= alu_carry.
  - All other opcodes, including JNC: carry_flag <= 0.
  - JNC tests the value from before the update.
- After EXEC: → FETCH if run=1, else → IDLE.
- Throughput with run=1: one instruction per ROM_LATENCY+1 cycles.
- Run changes: run deasserted during FETCH/EXEC completes the current instruction, then goes to IDLE. A step edge while run=1 or busy=1 is ignored (not queued).
- Reset asserted mid-instruction aborts immediately; no strobes are issued.
- PC wrap 15 → 0 is handled by program_counter; the sequencer does not care.

Optional Feature:
- Macro TD4_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in EXEC asserts illegal, does not assert pc_inc, and enters HALT. HALT has busy=0, all strobes 0, ignores run and step, and exits only on reset.
- Undefined: NOP behaviour as described above.

Decomposition:
- Package td4_pkg:
  - opcode constants (OP_ADD_A … OP_JMP);
  - sel encodings (SEL_A, SEL_B, SEL_IN, SEL_ZERO);
  - load bit indices (LD_A, LD_B, LD_OUT, LD_PC);
  - state enumeration.
- Sub-module td4_decode: combinational opcode + carry_flag → {load, sel, pc_inc, is_add, illegal}. The FSM gates its outputs with EXEC.

Test Plan:
- Reset, then run=1, ROM_LATENCY=1, rom_data=8'h35 (MOV A,5) → EXEC on cycle 2 after release; load=0001, sel=11, imm=5, pc_inc=1.
- ADD A,Im with alu_carry=1, then JNC 8'hE3 → carry_flag=1 after the ADD; JNC gives pc_inc=1, load[3]=0; carry_flag then clears to 0.
- JNC with carry_flag=0, rom_data=8'hE7 → load=1000, imm=7, pc_inc=0.
- run=0, step held high 10 cycles → exactly one FETCH/EXEC, then IDLE with busy=0; second step edge → one more instruction.
- ROM_LATENCY=3, run=1 → EXEC every 4th cycle. Deassert run mid-FETCH → that instruction completes, then IDLE.
- rom_data=8'h80 → without the macro: illegal pulse, pc_inc=1, execution continues. With TD4_ILLEGAL_TRAP_EN: HALT, no pc_inc, leaves HALT only on reset=0.
